// File: rtl/matrix_result_writer.sv
// Matrix result writer: captures one batch of CORE_COUNT lane results and
// writes the in-range lanes to consecutive result-memory words starting at
// row*C + column, one word per accepted memory handshake. Signals a single
// done pulse once the upstream sequencer is finished and every write has landed.
module matrix_result_writer #(
  parameter int CORE_COUNT = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16
) (
  input  logic                         CLOCK_25,
  input  logic                         rst,
  input  logic [CORE_COUNT*DATA_W-1:0] i_results,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [4:0]                   i_row,
  input  logic [4:0]                   i_core_column,
  input  logic [7:0]                   s_matrix_column_size,
  output logic                         o_wr_en,
  output logic [ADDR_W-1:0]            o_wr_addr,
  output logic [DATA_W-1:0]            o_wr_data,
  input  logic                         i_wr_ready,
  input  logic                         i_finished,
  output logic                         o_done,
  output logic [15:0]                  o_write_count
);

  localparam int LANE_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(CORE_COUNT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t                         state_q, state_d;
  logic [LANE_W-1:0]              lane_q, lane_d;
  logic [CORE_COUNT*DATA_W-1:0]   results_q, results_d;
  logic [ADDR_W-1:0]              base_q, base_d;
  logic [4:0]                     col_q, col_d;
  logic                           pending_q, pending_d;
  logic                           ready_q, ready_d;
  logic                           wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]              wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]              wr_data_q, wr_data_d;
  logic                           done_q, done_d;
  logic [15:0]                    count_q, count_d;

  logic [12:0]       prod_s;
  logic [ADDR_W-1:0] base_s;
  logic              in_range_s;
  logic              complete_s;
  logic              last_s;
  logic [LANE_W-1:0] lane_next_s;
  logic              pend_next_s;
  logic              fire_s;

  // Address arithmetic and lane bookkeeping shared by the next-state logic.
  always_comb begin
    prod_s      = {8'b0, i_row} * {5'b0, s_matrix_column_size};
    base_s      = ADDR_W'(prod_s) + ADDR_W'(i_core_column);
    in_range_s  = ({3'b000, i_core_column} < s_matrix_column_size);
    complete_s  = wr_en_q && i_wr_ready;
    lane_next_s = lane_q + LANE_W'(1);
    // Batch ends on the last physical lane or on the last matrix column.
    last_s      = (lane_q == LAST_LANE) ||
                  (({4'b0, col_q} + {{(9 - LANE_W){1'b0}}, lane_q} + 9'd1) >=
                   {1'b0, s_matrix_column_size});
  end

  // Next-state, write-port and completion/done logic.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    results_d = results_q;
    base_d    = base_q;
    col_d     = col_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      IDLE: begin
        if (i_valid && ready_q) begin
          if (in_range_s) begin
            results_d = i_results;
            base_d    = base_s;
            col_d     = i_core_column;
            lane_d    = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = base_s;
            wr_data_d = i_results[DATA_W-1:0];
            state_d   = WRITE;
          end else begin
            // Column outside the matrix: drop the batch silently.
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (complete_s) begin
          if (last_s) begin
            wr_en_d = 1'b0;
            state_d = IDLE;
          end else begin
            lane_d    = lane_next_s;
            wr_addr_d = base_q + ADDR_W'(lane_next_s);
            wr_data_d = results_q[int'(lane_next_s) * DATA_W +: DATA_W];
          end
        end else begin
          // Memory stalled: hold address and data.
          state_d = WRITE;
        end
      end
      default: begin
        state_d = IDLE;
        wr_en_d = 1'b0;
      end
    endcase

    count_d     = complete_s ? (count_q + 16'd1) : count_q;
    pend_next_s = pending_q || complete_s;
    // Done is decided on the edge that lands the final write so the pulse
    // shows in the first IDLE cycle; it can never coincide with WRITE.
    fire_s      = (state_d == IDLE) && i_finished && pend_next_s;
    done_d      = fire_s;
    pending_d   = fire_s ? 1'b0 : pend_next_s;
    ready_d     = (state_d == IDLE);
  end

  // State and output registers; reset aborts any in-flight batch.
  always_ff @(posedge CLOCK_25 or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      lane_q    <= '0;
      results_q <= '0;
      base_q    <= '0;
      col_q     <= 5'd0;
      pending_q <= 1'b0;
      ready_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      results_q <= results_d;
      base_q    <= base_d;
      col_q     <= col_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      count_q   <= count_d;
    end
  end

  assign o_ready       = ready_q;
  assign o_wr_en       = wr_en_q;
  assign o_wr_addr     = wr_addr_q;
  assign o_wr_data     = wr_data_q;
  assign o_done        = done_q;
  assign o_write_count = count_q;

endmodule

// File: tb/tb_matrix_result_writer.sv
// Self-checking bench for matrix_result_writer: directed and random batches
// compared against an address/data queue built from row*C + column + lane.
module tb_matrix_result_writer;

  localparam int CC = 4;
  localparam int DW = 32;
  localparam int AW = 16;

  logic             CLOCK_25 = 1'b0;
  logic             rst = 1'b0;
  logic [CC*DW-1:0] i_results = '0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [4:0]       i_row = 5'd0;
  logic [4:0]       i_core_column = 5'd0;
  logic [7:0]       csz = 8'd8;
  logic             o_wr_en;
  logic [AW-1:0]    o_wr_addr;
  logic [DW-1:0]    o_wr_data;
  logic             i_wr_ready = 1'b0;
  logic             i_finished = 1'b0;
  logic             o_done;
  logic [15:0]      o_write_count;

  matrix_result_writer #(.CORE_COUNT(CC), .DATA_W(DW), .ADDR_W(AW)) dut (
    .CLOCK_25(CLOCK_25), .rst(rst), .i_results(i_results), .i_valid(i_valid),
    .o_ready(o_ready), .i_row(i_row), .i_core_column(i_core_column),
    .s_matrix_column_size(csz), .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr),
    .o_wr_data(o_wr_data), .i_wr_ready(i_wr_ready), .i_finished(i_finished),
    .o_done(o_done), .o_write_count(o_write_count)
  );

  always #20 CLOCK_25 = ~CLOCK_25;

  int          n_vec = 0;
  int          n_mis = 0;
  logic [15:0] exp_a[$];
  logic [31:0] exp_d[$];
  logic [15:0] cnt_m = 16'd0;
  bit          pend_m = 1'b0;
  bit          fin = 1'b0;
  logic [31:0] res[CC];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic randomize_res();
    for (int k = 0; k < CC; k++) res[k] = $urandom;
  endtask

  task automatic set_inputs(input logic [4:0] row, input logic [4:0] col);
    i_row = row;
    i_core_column = col;
    for (int k = 0; k < CC; k++) i_results[k*DW +: DW] = res[k];
    i_valid = 1'b1;
  endtask

  // Drive a batch from a negedge and let the next posedge accept it.
  task automatic issue(input logic [4:0] row, input logic [4:0] col);
    set_inputs(row, col);
    chk("ready_before_accept", {63'd0, o_ready}, 64'd1);
    @(posedge CLOCK_25);
  endtask

  // Reference: lanes whose column lies inside the matrix, in lane order.
  task automatic push_exp(input logic [4:0] row, input logic [4:0] col);
    int a;
    for (int k = 0; k < CC; k++) begin
      if (int'(col) + k < int'(csz)) begin
        a = int'(row) * int'(csz) + int'(col) + k;
        exp_a.push_back(a[15:0]);
        exp_d.push_back(res[k]);
      end
    end
  endtask

  // Consume expected writes; hold_lane stalls that lane 3 cycles, fin_at
  // raises i_finished once that many writes have completed.
  task automatic drain(input int stall_pct, input int hold_lane, input int fin_at);
    int budget = 0;
    int done_w = 0;
    int holds = 0;
    while (exp_a.size() > 0 && budget < 400) begin
      @(negedge CLOCK_25);
      budget++;
      if (done_w == fin_at) begin
        i_finished = 1'b1;
        fin = 1'b1;
      end
      chk("wr_en_in_write", {63'd0, o_wr_en}, 64'd1);
      chk("wr_addr", {48'd0, o_wr_addr}, {48'd0, exp_a[0]});
      chk("wr_data", {32'd0, o_wr_data}, {32'd0, exp_d[0]});
      chk("ready_in_write", {63'd0, o_ready}, 64'd0);
      chk("done_in_write", {63'd0, o_done}, 64'd0);
      if (done_w == hold_lane && holds < 3) begin
        i_wr_ready = 1'b0;
        holds++;
      end else begin
        i_wr_ready = ($urandom_range(99) >= stall_pct);
      end
      @(posedge CLOCK_25);
      if (i_wr_ready) begin
        void'(exp_a.pop_front());
        void'(exp_d.pop_front());
        done_w++;
        cnt_m++;
        pend_m = 1'b1;
      end
    end
    chk("writes_drained", 64'(exp_a.size()), 64'd0);
    exp_a.delete();
    exp_d.delete();
    @(negedge CLOCK_25);
    chk("wr_en_after_batch", {63'd0, o_wr_en}, 64'd0);
    chk("ready_after_batch", {63'd0, o_ready}, 64'd1);
    chk("write_count", {48'd0, o_write_count}, {48'd0, cnt_m});
    chk("done_after_batch", {63'd0, o_done}, {63'd0, (fin && pend_m)});
    if (fin && pend_m) pend_m = 1'b0;
  endtask

  task automatic idle_checks(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_25);
      chk({tag, "_wr_en"}, {63'd0, o_wr_en}, 64'd0);
      chk({tag, "_ready"}, {63'd0, o_ready}, 64'd1);
      chk({tag, "_count"}, {48'd0, o_write_count}, {48'd0, cnt_m});
      chk({tag, "_done"}, {63'd0, o_done}, 64'd0);
    end
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge CLOCK_25);
    @(negedge CLOCK_25);
    chk("rst_wr_en", {63'd0, o_wr_en}, 64'd0);
    chk("rst_ready", {63'd0, o_ready}, 64'd0);
    chk("rst_count", {48'd0, o_write_count}, 64'd0);
    chk("rst_addr", {48'd0, o_wr_addr}, 64'd0);
    chk("rst_data", {32'd0, o_wr_data}, 64'd0);
    chk("rst_done", {63'd0, o_done}, 64'd0);
    rst = 1'b1;
    @(posedge CLOCK_25);
    @(negedge CLOCK_25);
    chk("ready_after_release", {63'd0, o_ready}, 64'd1);

    // Finished with nothing written: no done.
    i_finished = 1'b1;
    fin = 1'b1;
    idle_checks(3, "fin_no_writes");
    i_finished = 1'b0;
    fin = 1'b0;

    // C=8, row 2, column 4, full batch without stalls -> addr 20..23.
    csz = 8'd8;
    res[0] = 32'd11; res[1] = 32'd22; res[2] = 32'd33; res[3] = 32'd44;
    issue(5'd2, 5'd4);
    #1 i_valid = 1'b0;
    push_exp(5'd2, 5'd4);
    drain(0, -1, -1);
    chk("count_after_first", {48'd0, o_write_count}, 64'd4);

    // C=6, column 4: only two lanes fit.
    csz = 8'd6;
    randomize_res();
    issue(5'd0, 5'd4);
    #1 i_valid = 1'b0;
    push_exp(5'd0, 5'd4);
    drain(0, -1, -1);

    // Lane 1 stalled three cycles.
    csz = 8'd8;
    randomize_res();
    issue(5'(($urandom_range(31))), 5'd0);
    #1 i_valid = 1'b0;
    push_exp(i_row, 5'd0);
    drain(0, 1, -1);

    // Column equal to C: discarded.
    randomize_res();
    issue(5'd3, 5'd8);
    #1 i_valid = 1'b0;
    idle_checks(3, "discard");

    // New batch presented while the first is writing.
    randomize_res();
    issue(5'd1, 5'd2);
    #1 push_exp(5'd1, 5'd2);
    randomize_res();
    set_inputs(5'd5, 5'd1);
    drain(30, -1, -1);
    @(posedge CLOCK_25);
    #1 i_valid = 1'b0;
    push_exp(5'd5, 5'd1);
    drain(0, -1, -1);

    // i_finished raised mid-batch: done right after the last write, once.
    randomize_res();
    issue(5'd4, 5'd0);
    #1 i_valid = 1'b0;
    push_exp(5'd4, 5'd0);
    drain(0, -1, 2);
    idle_checks(4, "fin_held");
    i_finished = 1'b0;
    fin = 1'b0;

    // Random batches.
    for (int it = 0; it < 25; it++) begin
      csz = 8'($urandom_range(1, 40));
      randomize_res();
      issue(5'($urandom_range(31)), 5'($urandom_range(31)));
      #1 i_valid = 1'b0;
      push_exp(i_row, i_core_column);
      if (exp_a.size() == 0) idle_checks(1, "rand_discard");
      else drain($urandom_range(0, 60), -1, -1);
    end

    // Reset during lane 2.
    csz = 8'd8;
    randomize_res();
    issue(5'd3, 5'd0);
    #1 i_valid = 1'b0;
    push_exp(5'd3, 5'd0);
    i_wr_ready = 1'b1;
    repeat (2) begin
      @(negedge CLOCK_25);
      chk("pre_rst_addr", {48'd0, o_wr_addr}, {48'd0, exp_a[0]});
      @(posedge CLOCK_25);
      void'(exp_a.pop_front());
      void'(exp_d.pop_front());
    end
    @(negedge CLOCK_25);
    chk("lane2_addr", {48'd0, o_wr_addr}, {48'd0, exp_a[0]});
    rst = 1'b0;
    #1;
    chk("async_rst_wr_en", {63'd0, o_wr_en}, 64'd0);
    chk("async_rst_count", {48'd0, o_write_count}, 64'd0);
    chk("async_rst_ready", {63'd0, o_ready}, 64'd0);
    chk("async_rst_addr", {48'd0, o_wr_addr}, 64'd0);
    exp_a.delete();
    exp_d.delete();
    cnt_m = 16'd0;
    pend_m = 1'b0;
    @(negedge CLOCK_25);
    rst = 1'b1;
    @(posedge CLOCK_25);
    idle_checks(4, "after_abort");

    // Normal operation after the abort.
    randomize_res();
    issue(5'd7, 5'd6);
    #1 i_valid = 1'b0;
    push_exp(5'd7, 5'd6);
    drain(20, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/matrix_result_writer.md
MATRIX_RESULT_WRITER -- requirements
Module: matrix_result_writer

Interface
REQ-001 Parameter CORE_COUNT, 4, number of parallel MAC cores (lanes) per result batch.
REQ-002 Parameter DATA_W, 32, width of one core result.
REQ-003 Parameter ADDR_W, 16, result memory word-address width.
REQ-004 CLOCK_25  in  1  system clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 i_results  in  CORE_COUNT*DATA_W  lane k result at bits [k*DATA_W +: DATA_W].
REQ-007 i_valid  in  1  batch valid; upstream holds i_results/i_row/i_core_column stable until accepted.
REQ-008 o_ready  out  1  block can accept a batch.
REQ-009 i_row  in  5  result-matrix row of the batch.
REQ-010 i_core_column  in  5  result-matrix column of lane 0.
REQ-011 s_matrix_column_size  in  8  result-matrix column count (C), static during a run.
REQ-012 o_wr_en  out  1  result memory write request.
REQ-013 o_wr_addr  out  ADDR_W  result memory word address.
REQ-014 o_wr_data  out  DATA_W  result memory write data.
REQ-015 i_wr_ready  in  1  memory accepts write this cycle when high with o_wr_en.
REQ-016 i_finished  in  1  upstream sequencer finished level.
REQ-017 o_done  out  1  one-cycle pulse: all results of the run written.
REQ-018 o_write_count  out  16  number of accepted memory writes since reset.

Function
REQ-019 States SHALL be IDLE and WRITE; o_ready SHALL equal (state==IDLE).
REQ-020 Batch SHALL be accepted on a rising edge with i_valid && o_ready: capture i_results, base = i_row*C + i_core_column (ADDR_W bits, modulo 2^ADDR_W), lane counter = 0, move to WRITE.
REQ-021 If i_core_column >= C at acceptance, batch SHALL be discarded with no write and state SHALL remain IDLE.
REQ-022 In WRITE, o_wr_en SHALL be 1, o_wr_addr = base + lane, o_wr_data = captured lane result, all registered-source (no combinational path from i_results).
REQ-023 A write SHALL complete only in a cycle with o_wr_en && i_wr_ready; otherwise outputs SHALL hold unchanged.
REQ-024 On completion, if lane == CORE_COUNT-1 or i_core_column+lane+1 >= C, state SHALL return to IDLE; else lane SHALL increment.
REQ-025 Accepted batch latency: first o_wr_en SHALL assert the cycle after acceptance; a batch of n valid lanes with i_wr_ready held high SHALL occupy exactly n WRITE cycles.
REQ-026 o_write_count SHALL increment by 1 per completed write, wrapping 0xFFFF->0x0000.
REQ-027 A sticky "pending" flag SHALL set on any completed write and clear when o_done fires.
REQ-028 o_done SHALL pulse for exactly one cycle when state==IDLE, i_finished==1, pending==1; never in WRITE.
REQ-029 i_finished rising while in WRITE SHALL defer o_done until the batch completes and state is IDLE.
REQ-030 i_valid arriving while in WRITE SHALL not be accepted and SHALL not disturb the in-flight batch.
REQ-031 Lane counter width SHALL be clog2(CORE_COUNT), min 1 bit.

Reset
REQ-032 rst low SHALL immediately force state IDLE, lane 0, pending 0, o_wr_en 0, o_wr_addr 0, o_wr_data 0, o_done 0, o_write_count 0, o_ready 0.
REQ-033 o_ready SHALL be 1 from the first edge after rst deasserts.
REQ-034 rst asserted mid-WRITE SHALL abort the batch with no further writes; the partial batch SHALL not be replayed.

Verification
REQ-035 C=8, row 2, core_column 4, results {11,22,33,44}, i_wr_ready=1 -> writes addr 20..23 data 11,22,33,44 on 4 consecutive cycles, o_write_count=4.
REQ-036 C=6, core_column 4, row 0 -> only addr 4,5 written, back to IDLE after 2 write cycles.
REQ-037 C=8, i_wr_ready low 3 cycles on lane 1 -> addr/data held 3 cycles, total 4 writes, no duplicates.
REQ-038 i_finished raised mid-batch -> o_done single pulse the cycle after the last write completes; no pulse if no write since last o_done.
REQ-039 rst low during lane 2 -> o_wr_en 0 asynchronously, o_write_count 0, o_ready 1 after release.
REQ-040 i_valid held in WRITE with new data -> accepted only after return to IDLE, second batch addresses correct; core_column=8 with C=8 -> no write.
